// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle generator slice: slot count and field
// widths, gamemode encodings, default screen size, LFSR taps and the slot
// record that holds one obstacle's bounding box.
package obstacle_pkg;

    localparam int NUM_OBS      = 10;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Galois taps for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        GM_INIT  = 2'b00,
        GM_RUN   = 2'b01,
        GM_PAUSE = 2'b10,
        GM_END   = 2'b11
    } gamemode_t;

    typedef struct packed {
        logic [X_W-1:0] x_left;
        logic [X_W-1:0] x_right;
        logic [Y_W-1:0] y_top;
        logic [Y_W-1:0] y_bottom;
    } slot_t;

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit right-shifting Galois LFSR.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, loads SEED
//   adv   - advance one step this cycle
//   state - current LFSR value
module obstacle_lfsr
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst)
            state <= SEED;
        else if (adv)
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/obstacle_generator.sv
// Obstacle generator: spawns obstacles at the right screen edge every
// SPAWN_INTERVAL in-game ticks with LFSR-chosen height and side, scrolls them
// left by the current speed each tick and retires them when they leave.
// Build option: define OBSTACLE_SPEEDUP_EN to raise the speed by one every
// SPEEDUP_SPAWNS accepted spawns, capped at MAX_SPEED.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   tick         - one-cycle frame strobe
//   gamemode     - 00 init (clear), 01 run, 10 paused, 11 ended (hold)
//   obstacle_x   - slot i at [i*20+:20] = {x_right, x_left}
//   obstacle_y   - slot i at [i*18+:18] = {y_bottom, y_top}
//   active_mask  - bit i set when slot i holds an obstacle
//   spawn_drop   - one-cycle pulse when a spawn found every slot busy
module obstacle_generator
    import obstacle_pkg::*;
#(
    parameter int          SCREEN_W       = SCREEN_W_DEF,
    parameter int          SCREEN_H       = SCREEN_H_DEF,
    parameter int          OBS_W          = 40,
    parameter int          MIN_H          = 60,
    parameter int          H_RANGE_BITS   = 7,
    parameter int          SPEED          = 2,
    parameter int          SPAWN_INTERVAL = 90,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          SPEEDUP_SPAWNS = 8,
    parameter int          MAX_SPEED      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [1:0]               gamemode,
    output logic [NUM_OBS*2*X_W-1:0] obstacle_x,
    output logic [NUM_OBS*2*Y_W-1:0] obstacle_y,
    output logic [NUM_OBS-1:0]       active_mask,
    output logic                     spawn_drop
);

    localparam int CNT_W = $clog2(SPAWN_INTERVAL + 1);
    localparam int IDX_W = $clog2(NUM_OBS);

    localparam logic [X_W-1:0] SPAWN_XL = X_W'(SCREEN_W);
    localparam logic [X_W-1:0] SPAWN_XR = X_W'(SCREEN_W + OBS_W - 1);
    localparam logic [Y_W-1:0] SCR_H    = Y_W'(SCREEN_H);
    localparam logic [Y_W-1:0] MIN_HY   = Y_W'(MIN_H);

    if (SCREEN_W + OBS_W - 1 > 1023 || MIN_H + 2**H_RANGE_BITS - 1 > SCREEN_H ||
        SPAWN_INTERVAL < 1 || LFSR_SEED == 16'h0000 || MAX_SPEED < SPEED ||
        SPEEDUP_SPAWNS < 1) begin : g_bad_params
        $error("obstacle_generator: parameter set out of range");
    end

    gamemode_t        gm;
    slot_t            slots [NUM_OBS];
    logic [CNT_W-1:0] spawn_cnt;
    logic [X_W-1:0]   speed;
    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic             run_tick, spawn_now, spawn_ok, has_free;
    logic [IDX_W-1:0] free_idx;
    logic [Y_W-1:0]   h;
    slot_t            new_slot;

    assign gm          = gamemode_t'(gamemode);
    assign run_tick    = (gm == GM_RUN) && tick;
    assign spawn_now   = run_tick && (spawn_cnt == CNT_W'(SPAWN_INTERVAL - 1));
    assign spawn_ok    = spawn_now && has_free;
    assign lfsr_unused = ^lfsr[14:0];

    // Lowest free slot, judged on the pre-tick mask so a slot retired by this
    // tick's scroll only becomes eligible on the next tick.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (!active_mask[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        h                = MIN_HY + Y_W'(lfsr[H_RANGE_BITS-1:0]);
        new_slot.x_left  = SPAWN_XL;
        new_slot.x_right = SPAWN_XR;
        if (lfsr[15]) begin
            new_slot.y_top    = SCR_H - h;
            new_slot.y_bottom = SCR_H - Y_W'(1);
        end else begin
            new_slot.y_top    = '0;
            new_slot.y_bottom = h - Y_W'(1);
        end
    end

    obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (spawn_ok),
        .state (lfsr)
    );

`ifdef OBSTACLE_SPEEDUP_EN
    localparam int ACC_W = $clog2(SPEEDUP_SPAWNS + 1);
    logic [ACC_W-1:0] acc_cnt;
    logic [X_W-1:0]   speed_q;

    always_ff @(posedge clk) begin
        if (rst || gm == GM_INIT) begin
            speed_q <= X_W'(SPEED);
            acc_cnt <= '0;
        end else if (spawn_ok) begin
            if (acc_cnt == ACC_W'(SPEEDUP_SPAWNS - 1)) begin
                acc_cnt <= '0;
                if (speed_q < X_W'(MAX_SPEED))
                    speed_q <= speed_q + X_W'(1);
            end else begin
                acc_cnt <= acc_cnt + ACC_W'(1);
            end
        end
    end

    assign speed = speed_q;
`else
    assign speed = X_W'(SPEED);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBS; i++) slots[i] <= '0;
            active_mask <= '0;
            spawn_cnt   <= '0;
            spawn_drop  <= 1'b0;
        end else begin
            spawn_drop <= 1'b0;
            if (gm == GM_INIT) begin
                for (int i = 0; i < NUM_OBS; i++) slots[i] <= '0;
                active_mask <= '0;
                spawn_cnt   <= '0;
            end else if (run_tick) begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (active_mask[i]) begin
                        if (slots[i].x_right < speed) begin
                            slots[i]       <= '0;
                            active_mask[i] <= 1'b0;
                        end else begin
                            slots[i].x_right <= slots[i].x_right - speed;
                            slots[i].x_left  <= (slots[i].x_left >= speed) ?
                                                slots[i].x_left - speed : '0;
                        end
                    end
                end
                if (spawn_now) begin
                    spawn_cnt <= '0;
                    // The target was inactive, so the scroll above never
                    // touched it; this load is its only write this cycle.
                    if (has_free) begin
                        slots[free_idx]       <= new_slot;
                        active_mask[free_idx] <= 1'b1;
                    end else begin
                        spawn_drop <= 1'b1;
                    end
                end else begin
                    spawn_cnt <= spawn_cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_out
        assign obstacle_x[g*2*X_W +: 2*X_W] = {slots[g].x_right, slots[g].x_left};
        assign obstacle_y[g*2*Y_W +: 2*Y_W] = {slots[g].y_bottom, slots[g].y_top};
    end

endmodule

// File: doc/obstacle_generator.md
Name: obstacle_generator

Overview:
- Produces the packed obstacle bus (10 slots) that game_logic consumes for the player-vs-obstacle interaction, and that the renderer draws.
- Spawns obstacles at the right screen edge at fixed tick intervals, with pseudo-random height and side, and scrolls them left each frame tick.
- Follows gamemode from game_logic: clears on initial, runs in-game, freezes on paused or ended.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- OBS_W, 40, obstacle width in pixels.
- MIN_H, 60, minimum obstacle height.
- H_RANGE_BITS, 7, LFSR bits added to MIN_H for the height.
- SPEED, 2, pixels scrolled per tick (initial speed under SPEEDUP_EN).
- SPAWN_INTERVAL, 90, ticks between spawn attempts (≥1).
- LFSR_SEED, 16'hACE1, LFSR reset value (non-zero).
- SPEEDUP_SPAWNS, 8, accepted spawns per speed increment (SPEEDUP_EN only).
- MAX_SPEED, 8, speed cap (SPEEDUP_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle frame strobe
- gamemode  in  2  00 = initial, 01 = in-game, 10 = paused, 11 = ended
- obstacle_x  out  200  slot i at [i*20+:20] = {x_right[9:0], x_left[9:0]}
- obstacle_y  out  180  slot i at [i*18+:18] = {y_bottom[8:0], y_top[8:0]}
- active_mask  out  10  bit i = slot i valid
- spawn_drop  out  1  one-cycle pulse when a spawn finds no free slot

Behaviour:
- Reset: all slot fields 0, active_mask 0, spawn_drop 0, spawn counter 0, LFSR = LFSR_SEED, speed = SPEED. Reset wins over all other inputs in the same cycle.
- All outputs are registered. A tick sampled at edge N is reflected in the outputs after edge N.
- An inactive slot always drives all-zero x and y fields.
- gamemode 00, any cycle regardless of tick: clear all slots, active_mask, spawn counter and speed. The LFSR is not reset, so each round differs.
- gamemode 10 or 11: hold all state; ticks are ignored; spawn_drop stays 0.
- gamemode 01 with tick, applied to every active slot using pre-tick values:
  - If x_right < speed: deactivate the slot (all fields 0).
  - Otherwise: x_right -= speed, and x_left = (x_left ≥ speed) ? x_left − speed : 0.
- Spawn counter:
  - Increments on each in-game tick.
  - When it equals SPAWN_INTERVAL−1 on a tick, it wraps to 0 and a spawn is attempted in that same tick.
- Spawn attempt:
  - Target is the lowest-index slot that is inactive before this tick. A slot freed by this tick's scroll is not eligible until the next tick.
  - Load the target with x_left = SCREEN_W and x_right = SCREEN_W+OBS_W−1 (values ≥ SCREEN_W are offscreen; the renderer clips). The new slot is not scrolled on its spawn tick.
  - Height: h = MIN_H + lfsr[H_RANGE_BITS−1:0].
  - Side: lfsr[15] = 0 → y_top = 0, y_bottom = h−1. lfsr[15] = 1 → y_top = SCREEN_H−h, y_bottom = SCREEN_H−1.
  - The spawn uses the current LFSR value, then the LFSR advances one step. It advances only on an accepted spawn.
  - No free slot: no load, LFSR unchanged, spawn_drop = 1 for one cycle, and the counter still wraps.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400).
- Widths: all x arithmetic is 10-bit unsigned; y arithmetic is 9-bit. Parameters must keep SCREEN_W+OBS_W−1 ≤ 1023 and MIN_H+2^H_RANGE_BITS−1 ≤ SCREEN_H.

Optional Feature:
- OBSTACLE_SPEEDUP_EN defined:
  - Every SPEEDUP_SPAWNS accepted spawns, speed increments by 1, saturating at MAX_SPEED.
  - The new speed takes effect from the next tick.
  - Speed returns to SPEED on reset or on gamemode 00.
- Undefined: speed is constant at SPEED, and the SPEEDUP_SPAWNS / MAX_SPEED parameters are unused.

Decomposition:
- Shared package obstacle_pkg:
  - NUM_OBS = 10, X_W = 10, Y_W = 9.
  - Gamemode encodings GM_INIT, GM_RUN, GM_PAUSE, GM_END.
  - SCREEN_W / SCREEN_H defaults.
  - Slot struct {x_left, x_right, y_top, y_bottom}.
- One sub-module: obstacle_lfsr, a 16-bit Galois LFSR with seed parameter and advance enable, so other blocks can reuse it.

Test Plan:
- Reset, then gamemode = 01 with 89 ticks → all outputs 0, active_mask 0.
- 90th tick → slot 0 = x 640/679, y 323/479 (h = 60+97 = 157, bottom side). Next tick → x 638/677.
- gamemode = 10, then 11, each with 20 ticks → outputs unchanged. Then gamemode = 00 with no tick → all slots 0 the next cycle.
- Slot with x_left = 1, x_right = 40 on a tick → 0/38. Slot with x_right = 1 → deactivated and mask bit cleared.
- SPAWN_INTERVAL = 1, 10 ticks → active_mask = 10'h3FF. 11th tick → spawn_drop pulses once, no slot overwritten.
- rst = 1 in the same cycle as an in-game tick with 3 active slots → all cleared, no scroll, LFSR = 16'hACE1.
